gray_code_counter: RTL

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_pkg.sv | 41 ++++
 rtl/gray_step_chk.sv | 39 +++
 rtl/gray_code_counter.sv | 97 +++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and end-of-range mode constants for the Gray counter.
// The conversion functions work on a wide word, so callers zero-extend on the way in and size-cast on the way out.
package gray_pkg;

   localparam int GRAY_MAX_W = 64;

   localparam int SAT_WRAP = 0;
   localparam int SAT_HOLD = 1;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_LOAD = 2'd1,
      OP_STEP = 2'd2
   } op_e;

   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Bin bit i is the XOR of all Gray bits at or above i. Zero upper bits leave narrower words unaffected.
   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic int unsigned popcount(input gray_word_t v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/gray_step_chk.sv
// Sticky integrity checker: flags any counting step whose Gray transition is not exactly one bit.
// Loads and saturation holds are not presented as steps, so they are exempt.
module gray_step_chk
   import gray_pkg::*;
#(
   parameter int BIT = 8
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_step,
   input  logic [BIT-1:0] i_gray_prev,
   input  logic [BIT-1:0] i_gray_next,
   output logic           o_err
);

   logic err_q;
   logic err_d;
   logic bad_step;

   always_comb begin
      bad_step = 1'b0;
      err_d    = err_q;
      if (i_step) begin
         bad_step = (popcount(GRAY_MAX_W'(i_gray_prev ^ i_gray_next)) != 32'd1);
      end
      err_d = err_q | bad_step;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign o_err = err_q;

endmodule

// File: rtl/gray_code_counter.sv
// Up/down counter holding both binary and Gray forms of the count, with load, wrap/saturate end-of-range
// handling, a terminal-count flag and a sticky Gray-step integrity error.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int BIT = 8,
   parameter int SAT = SAT_WRAP
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   input  logic           i_up,
   input  logic           i_load,
   input  logic [BIT-1:0] i_load_gray,
   output logic [BIT-1:0] o_bin,
   output logic [BIT-1:0] o_gray,
   output logic           o_tc,
   output logic           o_wrap,
   output logic           o_err
);

   logic [BIT-1:0] bin_q;
   logic [BIT-1:0] bin_d;
   logic [BIT-1:0] gray_q;
   logic [BIT-1:0] gray_d;
   logic           wrap_q;
   logic           wrap_d;

   op_e  op;
   logic at_term;
   logic sat_hold;
   logic chk_step;

   always_comb begin
      op = OP_HOLD;
      if (i_load) begin
         op = OP_LOAD;
      end else if (i_en) begin
         op = OP_STEP;
      end
   end

   always_comb begin
      at_term  = i_up ? (&bin_q) : ~(|bin_q);
      sat_hold = (SAT == SAT_HOLD) && at_term;
      bin_d    = bin_q;
      gray_d   = gray_q;
      wrap_d   = 1'b0;
      chk_step = 1'b0;
      unique case (op)
         OP_LOAD: begin
            bin_d  = BIT'(gray2bin(GRAY_MAX_W'(i_load_gray)));
            gray_d = i_load_gray;
         end
         OP_STEP: begin
            // A step at the terminal value in saturate mode is a hold, not a step.
            if (!sat_hold) begin
               bin_d    = i_up ? (bin_q + 1'b1) : (bin_q - 1'b1);
               gray_d   = BIT'(bin2gray(GRAY_MAX_W'(bin_d)));
               wrap_d   = at_term;
               chk_step = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bin_q  <= '0;
         gray_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   gray_step_chk #(
      .BIT (BIT)
   ) u_step_chk (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_step      (chk_step),
      .i_gray_prev (gray_q),
      .i_gray_next (gray_d),
      .o_err       (o_err)
   );

   assign o_bin  = bin_q;
   assign o_gray = gray_q;
   assign o_wrap = wrap_q;
   assign o_tc   = at_term;

endmodule
